mult_ctrl: RTL and testbench

Sequencing controller for the shift-add sequential multiplier. It drives the product register's load/shift/clear strobes and the operand-load strobe from a start/done handshake. It inspects the multiplier LSB each iteration to decide whether to add, and counts WIDTH iterations. It sits between the host logic and the product/multiplicand datapath.

---
 rtl/mult_ctrl.sv | 116 +++++++++++
 tb/tb_mult_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mult_ctrl : start/done sequencer for a shift-add multiplier (load, test,    |
// |             add, shift, WIDTH iterations). Option: MULT_CTRL_DONE_HOLD_EN   |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module mult_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          ack,
  input  logic          q0,
  output logic          lda,
  output logic          clrp,
  output logic          ldp,
  output logic          shp,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode from state_q only, so clr clears them without waiting for clk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lda     = 1'b0;
    clrp    = 1'b0;
    ldp     = 1'b0;
    shp     = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        lda     = 1'b1;
        clrp    = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        state_d = q0 ? ADD : SHIFT;
      end
      ADD: begin
        ldp     = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shp = 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = TEST;
        end
      end
      DONE: begin
        done = 1'b1;
`ifdef MULT_CTRL_DONE_HOLD_EN
        if (ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifndef MULT_CTRL_DONE_HOLD_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mult_ctrl : randomized bench for mult_ctrl with a behavioural datapath   |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module tb_mult_ctrl;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          clr, start, ack, q0;
  logic          lda, clrp, ldp, shp, busy, done;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]   a_op, b_op;
  logic [W-1:0]   m_q;
  logic [2*W-1:0] p_q;
  logic           c_q;

  always #5 clk = ~clk;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .ack(ack), .q0(q0),
    .lda(lda), .clrp(clrp), .ldp(ldp), .shp(shp),
    .busy(busy), .done(done), .cnt(cnt)
  );

  // Product/multiplicand datapath driven by the controller strobes.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q <= '0;
      p_q <= '0;
      c_q <= 1'b0;
    end else begin
      if (lda) begin
        m_q          <= a_op;
        p_q[W-1:0]   <= b_op;
      end
      if (clrp) begin
        p_q[2*W-1:W] <= '0;
        c_q          <= 1'b0;
      end
      if (ldp) {c_q, p_q[2*W-1:W]} <= {1'b0, p_q[2*W-1:W]} + {1'b0, m_q};
      if (shp) begin
        p_q <= {c_q, p_q[2*W-1:1]};
        c_q <= 1'b0;
      end
    end
  end
  assign q0 = p_q[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    check("drain_done", done, 1);
`ifdef MULT_CTRL_DONE_HOLD_EN
    ack = 1'b1;
`endif
    @(negedge clk);
    ack = 1'b0;
    check("drain_idle", busy, 0);
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int  lcount, scount, done_at;
    logic prev_test_q1;
    a_op  = a;
    b_op  = b;
    start = 1'b1;
    ack   = 1'b0;
    @(negedge clk);
    check("load_lda", lda, 1);
    check("load_clrp", clrp, 1);
    check("load_busy", busy, 1);
    if (!keep) start = 1'b0;
    lcount = 0; scount = 0; done_at = -1; prev_test_q1 = 1'b0;
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      @(negedge clk);
      check("ldp_shp_excl", ldp & shp, 0);
      check("lda_only_load", lda | clrp, 0);
      check("busy_in_op", busy, 1);
      if (ldp) begin
        lcount++;
        check("ldp_after_test_q1", prev_test_q1, 1);
      end
      if (shp) begin
        check("cnt_at_shift", cnt, scount);
        scount++;
      end
      prev_test_q1 = busy & ~done & ~lda & ~ldp & ~shp & q0;
      if (done) done_at = k;
    end
    check("done_edge", done_at, 1 + 2*W + $countones(b));
    if (done_at < 0) return;
    check("product", p_q, a * b);
    check("ldp_pulses", lcount, $countones(b));
    check("shp_pulses", scount, W);
`ifdef MULT_CTRL_DONE_HOLD_EN
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("done_held", done, 1);
      check("busy_held", busy, 1);
      check("start_ignored_done", lda, 0);
    end
    ack   = 1'b1;
    start = keep;
    @(negedge clk);
    ack = 1'b0;
`else
    start = 1'b1;
    @(negedge clk);
    start = keep;
`endif
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
    check("idle_cnt", cnt, 0);
    if (keep) begin
      @(negedge clk);
      check("relaunch_lda", lda, 1);
      start = 1'b0;
      drain();
    end
  endtask

  task automatic reset_test();
    a_op  = 4'd7;
    b_op  = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !ldp; k++) @(negedge clk);
    check("reached_add", ldp, 1);
    #2 clr = 1'b1;
    #1;
    check("async_rst_outs", {lda, clrp, ldp, shp, busy, done}, 0);
    check("async_rst_cnt", cnt, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {lda, clrp, ldp, shp, busy, done, cnt}, 0);
    end
  endtask

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    a_op  = '0;
    b_op  = '0;
    #1;
    check("rst_outs", {lda, clrp, ldp, shp, busy, done}, 0);
    check("rst_cnt", cnt, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 0);

    run_mult(4'd7, 4'd7, 1'b0);
    run_mult(4'($urandom), 4'd0, 1'b0);
    run_mult(4'd15, 4'd15, 1'b0);
    for (int b = 0; b < 16; b++) run_mult(4'($urandom_range(0, 15)), 4'(b), 1'b0);
    run_mult(4'($urandom), 4'($urandom), 1'b1);
    reset_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
